// File: rtl/csc_stream_sram_bank.sv
// CSC stream buffer for one GLB bank: address and data SRAMs with zero-terminated
// streams, independent write/read session FSMs, overflow and stored-length reporting.
module csc_stream_sram_bank #(
   parameter int ADDR_W     = 7,
   parameter int DATA_W     = 12,
   parameter int ADDR_DEPTH = 16,
   parameter int DATA_DEPTH = 32,
   parameter int AP_W       = $clog2(ADDR_DEPTH),
   parameter int DP_W       = $clog2(DATA_DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              addr_in_valid,
   output logic              addr_in_ready,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic              data_in_valid,
   output logic              data_in_ready,
   input  logic [DATA_W-1:0] data_in,
   output logic              addr_out_valid,
   input  logic              addr_out_ready,
   output logic [ADDR_W-1:0] addr_out,
   output logic              data_out_valid,
   input  logic              data_out_ready,
   output logic [DATA_W-1:0] data_out,
   input  logic              write_en,
   output logic              write_done,
   input  logic              read_en,
   input  logic [DP_W-1:0]   read_addr,
   output logic              read_done,
   input  logic              abort,
   output logic [AP_W:0]     addr_count,
   output logic [DP_W:0]     data_count,
   output logic              overflow,
   output logic              write_busy,
   output logic              read_busy,
   output logic [1:0]        write_state,
   output logic [1:0]        read_state
);

   // Every stream port is valid/ready: a word moves on a clock edge where both
   // valid and ready are high; a valid word is held stable until it is taken.

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WORK      = 2'd1,
      WAIT_ADDR = 2'd2,
      WAIT_DATA = 2'd3
   } state_t;

   localparam logic [AP_W-1:0] A_END   = AP_W'(ADDR_DEPTH - 1);
   localparam logic [DP_W-1:0] D_END   = DP_W'(DATA_DEPTH - 1);
   localparam logic [AP_W-1:0] A_STEP  = AP_W'(1);
   localparam logic [DP_W-1:0] D_STEP  = DP_W'(1);
   localparam logic [AP_W:0]   AC_STEP = (AP_W + 1)'(1);
   localparam logic [DP_W:0]   DC_STEP = (DP_W + 1)'(1);

   logic [ADDR_W-1:0] addr_mem [ADDR_DEPTH];
   logic [DATA_W-1:0] data_mem [DATA_DEPTH];

   state_t w_state, w_next;
   state_t r_state, r_next;

   // ---------------------------------------------------------------- write side
   logic            w_start, wa_act, wd_act, wa_hs, wd_hs, wa_end, wd_end, wa_fin, wd_fin;
   logic [AP_W-1:0] wa_ptr;
   logic [DP_W-1:0] wd_ptr;

   assign w_start       = (w_state == IDLE) && write_en && !abort;
   assign wa_act        = (w_state == WORK) || (w_state == WAIT_ADDR);
   assign wd_act        = (w_state == WORK) || (w_state == WAIT_DATA);
   assign addr_in_ready = wa_act;
   assign data_in_ready = wd_act;
   assign wa_hs         = addr_in_valid && wa_act;
   assign wd_hs         = data_in_valid && wd_act;
   assign wa_end        = (wa_ptr == A_END);
   assign wd_end        = (wd_ptr == D_END);
   assign wa_fin        = wa_hs && ((addr_in == '0) || wa_end);
   assign wd_fin        = wd_hs && ((data_in == '0) || wd_end);

   always_ff @(posedge clock) begin
      if (reset) w_state <= IDLE;
      else       w_state <= w_next;
   end

   always_comb begin
      w_next     = w_state;
      write_done = 1'b0;
      case (w_state)
         IDLE: if (write_en) w_next = WORK;
         WORK: begin
            if (wa_fin && wd_fin) begin
               w_next     = IDLE;
               write_done = 1'b1;
            end else if (wa_fin) begin
               w_next = WAIT_DATA;
            end else if (wd_fin) begin
               w_next = WAIT_ADDR;
            end
         end
         WAIT_ADDR: if (wa_fin) begin
            w_next     = IDLE;
            write_done = 1'b1;
         end
         WAIT_DATA: if (wd_fin) begin
            w_next     = IDLE;
            write_done = 1'b1;
         end
         default: w_next = IDLE;
      endcase
      if (abort) begin
         w_next     = IDLE;
         write_done = 1'b0;
      end
   end

   // Pointers park on the last entry; a nonzero word there ends the stream as overflow.
   always_ff @(posedge clock) begin
      if (reset) begin
         wa_ptr     <= '0;
         wd_ptr     <= '0;
         addr_count <= '0;
         data_count <= '0;
         overflow   <= 1'b0;
      end else if (w_start) begin
         wa_ptr     <= '0;
         wd_ptr     <= '0;
         addr_count <= '0;
         data_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (wa_hs) begin
            addr_count <= addr_count + AC_STEP;
            if (!wa_end)              wa_ptr   <= wa_ptr + A_STEP;
            if (wa_end && addr_in != '0) overflow <= 1'b1;
         end
         if (wd_hs) begin
            data_count <= data_count + DC_STEP;
            if (!wd_end)              wd_ptr   <= wd_ptr + D_STEP;
            if (wd_end && data_in != '0) overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && wa_hs) addr_mem[wa_ptr] <= addr_in;
      if (!reset && wd_hs) data_mem[wd_ptr] <= data_in;
   end

   // ----------------------------------------------------------------- read side
   logic              r_start, ra_act, rd_act, ra_issue, rd_issue, ra_last_now, rd_last_now;
   logic              ra_fin, rd_fin, ra_issued_last, rd_issued_last, ra_out_last, rd_out_last;
   logic [AP_W-1:0]   ra_ptr;
   logic [DP_W-1:0]   rd_ptr;
   logic [ADDR_W-1:0] ra_word;
   logic [DATA_W-1:0] rd_word;

   // Asynchronous array read sees the pre-write contents: read-first on collision.
   assign ra_word     = addr_mem[ra_ptr];
   assign rd_word     = data_mem[rd_ptr];
   assign r_start     = (r_state == IDLE) && read_en && !abort;
   assign ra_act      = (r_state == WORK) || (r_state == WAIT_ADDR);
   assign rd_act      = (r_state == WORK) || (r_state == WAIT_DATA);
   assign ra_issue    = ra_act && !ra_issued_last && (!addr_out_valid || addr_out_ready);
   assign rd_issue    = rd_act && !rd_issued_last && (!data_out_valid || data_out_ready);
   assign ra_last_now = (ra_word == '0) || (ra_ptr == A_END);
   assign rd_last_now = (rd_word == '0) || (rd_ptr == D_END);
   assign ra_fin      = ra_act && addr_out_valid && addr_out_ready && ra_out_last;
   assign rd_fin      = rd_act && data_out_valid && data_out_ready && rd_out_last;

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= r_next;
   end

   always_comb begin
      r_next    = r_state;
      read_done = 1'b0;
      case (r_state)
         IDLE: if (read_en) r_next = WORK;
         WORK: begin
            if (ra_fin && rd_fin) begin
               r_next    = IDLE;
               read_done = 1'b1;
            end else if (ra_fin) begin
               r_next = WAIT_DATA;
            end else if (rd_fin) begin
               r_next = WAIT_ADDR;
            end
         end
         WAIT_ADDR: if (ra_fin) begin
            r_next    = IDLE;
            read_done = 1'b1;
         end
         WAIT_DATA: if (rd_fin) begin
            r_next    = IDLE;
            read_done = 1'b1;
         end
         default: r_next = IDLE;
      endcase
      if (abort) begin
         r_next    = IDLE;
         read_done = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ra_ptr         <= '0;
         ra_issued_last <= 1'b0;
         ra_out_last    <= 1'b0;
         addr_out_valid <= 1'b0;
         addr_out       <= '0;
      end else if (abort) begin
         addr_out_valid <= 1'b0;
      end else if (r_start) begin
         ra_ptr         <= AP_W'(read_addr);
         ra_issued_last <= 1'b0;
         addr_out_valid <= 1'b0;
      end else if (ra_issue) begin
         addr_out       <= ra_word;
         addr_out_valid <= 1'b1;
         ra_out_last    <= ra_last_now;
         if (ra_last_now) ra_issued_last <= 1'b1;
         else             ra_ptr         <= ra_ptr + A_STEP;
      end else if (addr_out_valid && addr_out_ready) begin
         addr_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr         <= '0;
         rd_issued_last <= 1'b0;
         rd_out_last    <= 1'b0;
         data_out_valid <= 1'b0;
         data_out       <= '0;
      end else if (abort) begin
         data_out_valid <= 1'b0;
      end else if (r_start) begin
         rd_ptr         <= DP_W'(read_addr);
         rd_issued_last <= 1'b0;
         data_out_valid <= 1'b0;
      end else if (rd_issue) begin
         data_out       <= rd_word;
         data_out_valid <= 1'b1;
         rd_out_last    <= rd_last_now;
         if (rd_last_now) rd_issued_last <= 1'b1;
         else             rd_ptr         <= rd_ptr + D_STEP;
      end else if (data_out_valid && data_out_ready) begin
         data_out_valid <= 1'b0;
      end
   end

   assign write_busy  = (w_state != IDLE);
   assign read_busy   = (r_state != IDLE);
   assign write_state = w_state;
   assign read_state  = r_state;

endmodule

// File: doc/csc_stream_sram_bank.md
Name: csc_stream_sram_bank

Overview:
Parametrised compressed-sparse-column (CSC) stream buffer for one GLB iact or weight bank. It holds an address SRAM and a data SRAM internally, each with its own write/read pointers and end-of-stream detection (a zero word terminates a stream). Independent write and read FSMs produce one combined write_done or read_done pulse once both streams have terminated, in either order. Compared with the fixed iact bank, it adds:
- parametrised widths and depths
- overflow detection
- stored-length reporting
- an abort input
- full-throughput read pipelining

Parameters:
ADDR_W, 7, address-stream word width
DATA_W, 12, data-stream word width
ADDR_DEPTH, 16, address SRAM entries (power of 2, >=2)
DATA_DEPTH, 32, data SRAM entries (power of 2, >=2)
AP_W, $clog2(ADDR_DEPTH), address-SRAM pointer width (derived)
DP_W, $clog2(DATA_DEPTH), data-SRAM pointer width (derived)

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
addr_in_valid / addr_in_ready / addr_in  in/out/in  1/1/ADDR_W  address write stream
data_in_valid / data_in_ready / data_in  in/out/in  1/1/DATA_W  data write stream
addr_out_valid / addr_out_ready / addr_out  out/in/out  1/1/ADDR_W  address read stream
data_out_valid / data_out_ready / data_out  out/in/out  1/1/DATA_W  data read stream
write_en  in  1  start write session (pulse)
write_done  out  1  one-cycle pulse: both streams written
read_en  in  1  start read session (pulse)
read_addr  in  DP_W  start entry for read session; each stream uses low bits of its own pointer width
read_done  out  1  one-cycle pulse: both streams read
abort  in  1  cancel both sessions
addr_count  out  AP_W+1  words stored in address SRAM by last write session
data_count  out  DP_W+1  words stored in data SRAM by last write session
overflow  out  1  sticky: last write session filled a SRAM without a terminator
write_busy / read_busy  out  1/1  FSM not IDLE

Behaviour:
Reset values:
- All valid, ready and done outputs 0.
- Counts 0, overflow 0, both FSMs IDLE.
- SRAM contents are not reset.

Both FSMs use states IDLE=0, WORK=1, WAIT_ADDR=2, WAIT_DATA=3.
- Stream enables: addr stream active in WORK or WAIT_ADDR; data stream active in WORK or WAIT_DATA.
- IDLE -> WORK on en.
- WORK -> IDLE if both streams finish in the same cycle.
- WORK -> WAIT_DATA if only addr finishes; WORK -> WAIT_ADDR if only data finishes.
- WAIT_x -> IDLE when stream x finishes.
- done pulses in the cycle the last stream finishes, combinationally from the finish events, same cycle as the transition to IDLE.
- write_en or read_en while busy: ignored.

Write session:
- On write_en in IDLE: both wptrs cleared, both counts cleared, overflow cleared.
- *_in_ready = stream active and not finished.
- On handshake: mem[wptr] <= word, wptr++, count++.
- Stream finishes on the handshake of a zero word; the terminator is stored and counted.
- If the handshake occurs at wptr = DEPTH-1 with a nonzero word: stream finishes and overflow is set. The pointer does not wrap.

Read session:
- On read_en in IDLE: each rptr loaded from read_addr, truncated to that stream's pointer width.
- Issue rule per stream: issue a read in cycle t if the stream is active, the stream has not issued its last word, and (!out_valid || out_ready).
- An issued word appears on *_out with *_out_valid=1 in cycle t+1.
- Sustained throughput is 1 word/cycle per stream.
- Last word = zero word, or the entry at DEPTH-1. No issue follows it.
- out_valid drops the cycle after a consume with no new issue.
- Data is held stable while valid && !ready.
- Stream finishes on the handshake of its last word.

Arbitration and abort:
- Simultaneous write and read to the same entry returns the old contents (read-first).
- Write and read sessions run concurrently and independently.
- abort: both FSMs -> IDLE next cycle. All out_valid and ready outputs are 0 from the next cycle. No done pulses. Counts hold the words accepted so far. abort has priority over en in the same cycle.
- reset mid-session behaves as abort and also clears counts and overflow.

Test Plan:
- Write addr {3,5,0} and data {7,9,11,2,4,0} concurrently, then read_en with read_addr=0, ready=1 -> addr_out 3,5,0 on consecutive cycles; data_out 7,9,11,2,4,0 back-to-back; write_done and read_done each pulse once, on the cycle of the later terminator; addr_count=3, data_count=6.
- Addr terminator accepted 4 cycles before data terminator -> state WAIT_DATA; write_done pulses exactly once, on the data-terminator cycle.
- Write 16 nonzero addr words (ADDR_DEPTH=16) with no zero -> addr stream finishes at entry 15, overflow=1, addr_count=16, addr_in_ready=0 afterwards.
- Read with addr_out_ready toggling 1,0,0,1 -> addr_out held stable while stalled; no word lost or duplicated; zero SRAM issues while the terminator is pending.
- abort asserted mid-read, two words into data -> both valids 0 the next cycle, read_busy=0, no read_done; a following read_en restarts from read_addr.
- read_en asserted while read_busy=1 -> ignored, no pointer reload; read_addr=4 on a fresh session -> first addr_out = mem[4].
